// File: rtl/eva_ahb_reg_slave.sv
// AHB-Lite register slave: ID, scratch, W1C interrupt block, free-running counter
// and general-purpose registers, with configurable data-phase wait states.
module eva_ahb_reg_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hE7A0_0001
) (
    input  logic        hclk,
    input  logic        rst_n,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [31:0] haddr,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hready_out,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata,
    output logic [31:0] irq
);
    localparam int          NUM_GEN   = NUM_REGS - 5;
    localparam logic [12:0] REG_LIMIT = 13'(NUM_REGS * 4);
    localparam logic [2:0]  WS_LOAD   = 3'(WAIT_STATES);

    localparam logic [9:0] OFF_ID         = 10'd0;
    localparam logic [9:0] OFF_SCRATCH    = 10'd1;
    localparam logic [9:0] OFF_IRQ_STATUS = 10'd2;
    localparam logic [9:0] OFF_IRQ_SET    = 10'd3;
    localparam logic [9:0] OFF_COUNTER    = 10'd4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR1,
        ERR2
    } state_t;

    state_t      state, state_nxt;
    logic        pend, pend_nxt;
    logic [2:0]  wcnt, wcnt_nxt;
    logic [9:0]  addr_q, addr_nxt;
    logic        write_q, write_nxt;

    logic        accept;
    logic        addr_err;
    logic        complete;
    logic        take;
    logic        commit;
    logic [31:0] rd_val;

    logic [31:0] scratch;
    logic [31:0] irq_status;
    logic [31:0] counter;
    logic [31:0] gen_regs [NUM_GEN];

    // A stray select outside the 4 KB window is answered with ERROR like any bad offset.
    assign accept   = hsel && hready && ((htrans == 2'b10) || (htrans == 2'b11));
    assign addr_err = (haddr[31:12] != BASE_ADDR[31:12])
                   || ({1'b0, haddr[11:0]} >= REG_LIMIT)
                   || (haddr[1:0] != 2'b00)
                   || (hsize != 3'b010);

    always_ff @(posedge hclk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pend    <= 1'b0;
            wcnt    <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            pend    <= pend_nxt;
            wcnt    <= wcnt_nxt;
            addr_q  <= addr_nxt;
            write_q <= write_nxt;
        end
    end

    // 'take' marks every cycle where hready_out is high, so a new address phase
    // can be accepted alongside a completing data phase without a bubble.
    always_comb begin
        state_nxt  = state;
        pend_nxt   = pend;
        wcnt_nxt   = wcnt;
        addr_nxt   = addr_q;
        write_nxt  = write_q;
        hready_out = 1'b1;
        hresp      = 2'b00;
        complete   = 1'b0;
        take       = 1'b0;
        case (state)
            IDLE: begin
                complete = pend;
                take     = 1'b1;
            end
            WAIT: begin
                if (wcnt != 3'd0) begin
                    hready_out = 1'b0;
                    wcnt_nxt   = wcnt - 3'd1;
                end else begin
                    complete = 1'b1;
                    take     = 1'b1;
                end
            end
            ERR1: begin
                hready_out = 1'b0;
                hresp      = 2'b01;
                state_nxt  = ERR2;
            end
            ERR2: begin
                hresp = 2'b01;
                take  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        if (take) begin
            pend_nxt  = 1'b0;
            state_nxt = IDLE;
            if (accept) begin
                addr_nxt  = haddr[11:2];
                write_nxt = hwrite;
                if (addr_err) begin
                    state_nxt = ERR1;
                end else if (WAIT_STATES == 0) begin
                    pend_nxt = 1'b1;
                end else begin
                    state_nxt = WAIT;
                    wcnt_nxt  = WS_LOAD;
                end
            end
        end
    end

    assign commit = complete && write_q;

    // The counter write overrides the free-running increment on the commit cycle.
    always_ff @(posedge hclk) begin
        if (!rst_n) begin
            scratch    <= '0;
            irq_status <= '0;
            counter    <= '0;
            for (int i = 0; i < NUM_GEN; i++) begin
                gen_regs[i] <= '0;
            end
        end else begin
            counter <= counter + 32'd1;
            if (commit) begin
                case (addr_q)
                    OFF_SCRATCH:    scratch    <= hwdata;
                    OFF_IRQ_STATUS: irq_status <= irq_status & ~hwdata;
                    OFF_IRQ_SET:    irq_status <= irq_status | hwdata;
                    OFF_COUNTER:    counter    <= hwdata;
                    default: ;
                endcase
            end
            for (int i = 0; i < NUM_GEN; i++) begin
                if (commit && (addr_q == 10'(i + 5))) begin
                    gen_regs[i] <= hwdata;
                end
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (addr_q)
            OFF_ID:         rd_val = ID_VALUE;
            OFF_SCRATCH:    rd_val = scratch;
            OFF_IRQ_STATUS: rd_val = irq_status;
            OFF_COUNTER:    rd_val = counter;
            default:        rd_val = '0;
        endcase
        for (int i = 0; i < NUM_GEN; i++) begin
            if (addr_q == 10'(i + 5)) begin
                rd_val = gen_regs[i];
            end
        end
    end

    assign hrdata = (complete && !write_q) ? rd_val : 32'd0;
    assign irq    = irq_status;

endmodule

// File: tb/tb_eva_ahb_reg_slave.sv
// Bench for eva_ahb_reg_slave: two instances (0 and 2 wait states) driven by a pipelined
// AHB driver and checked against a register-level model of the slave.
module tb_eva_ahb_reg_slave;
    localparam int          NUM_REGS = 16;
    localparam logic [31:0] BASE     = 32'h4000_0000;
    localparam logic [31:0] ID_VAL   = 32'hE7A0_0001;

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    logic        hclk;
    logic        rst_n;
    logic        hsel       [2];
    logic [1:0]  htrans     [2];
    logic        hwrite     [2];
    logic [31:0] haddr      [2];
    logic [2:0]  hsize      [2];
    logic [31:0] hwdata     [2];
    logic        hready_out [2];
    logic [1:0]  hresp      [2];
    logic [31:0] hrdata     [2];
    logic [31:0] irq        [2];

    logic [31:0] mreg [2][NUM_REGS];
    logic [31:0] mcnt [2];
    xfer_t       q0[$];
    xfer_t       q1[$];
    xfer_t       cur   [2];
    xfer_t       nxt   [2];
    logic        cur_v [2];
    logic        nxt_v [2];
    int          waits [2];
    int          n_checks;
    int          n_fail;

    eva_ahb_reg_slave #(.BASE_ADDR(BASE), .NUM_REGS(NUM_REGS), .WAIT_STATES(0), .ID_VALUE(ID_VAL)) dut0 (
        .hclk(hclk), .rst_n(rst_n), .hsel(hsel[0]), .htrans(htrans[0]), .hwrite(hwrite[0]),
        .haddr(haddr[0]), .hsize(hsize[0]), .hwdata(hwdata[0]), .hready(hready_out[0]),
        .hready_out(hready_out[0]), .hresp(hresp[0]), .hrdata(hrdata[0]), .irq(irq[0])
    );

    eva_ahb_reg_slave #(.BASE_ADDR(BASE), .NUM_REGS(NUM_REGS), .WAIT_STATES(2), .ID_VALUE(ID_VAL)) dut2 (
        .hclk(hclk), .rst_n(rst_n), .hsel(hsel[1]), .htrans(htrans[1]), .hwrite(hwrite[1]),
        .haddr(haddr[1]), .hsize(hsize[1]), .hwdata(hwdata[1]), .hready(hready_out[1]),
        .hready_out(hready_out[1]), .hresp(hresp[1]), .hrdata(hrdata[1]), .irq(irq[1])
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int wsOf(input int b);
        return (b == 0) ? 0 : 2;
    endfunction

    function automatic logic isXfer(input xfer_t x);
        return x.sel && x.trans[1];
    endfunction

    function automatic logic isErr(input xfer_t x);
        return (x.addr[31:12] != 20'h40000) || (x.addr[11:0] >= 12'(NUM_REGS * 4))
            || (x.addr[1:0] != 2'b00) || (x.size != 3'b010);
    endfunction

    function automatic logic [31:0] modelRead(input int b, input int idx);
        case (idx)
            0:       return ID_VAL;
            3:       return 32'd0;
            4:       return mcnt[b];
            default: return mreg[b][idx];
        endcase
    endfunction

    task automatic driveIdle(input int b);
        hsel[b]   = 1'b0;
        htrans[b] = 2'b00;
        hwrite[b] = 1'b0;
        haddr[b]  = $urandom();
        hsize[b]  = 3'b010;
    endtask

    task automatic queueXfer(input int b, input logic sel, input logic [1:0] tr, input logic wr,
                             input logic [31:0] addr, input logic [2:0] sz, input logic [31:0] wd);
        xfer_t x;
        x = '{sel: sel, trans: tr, wr: wr, addr: addr, size: sz, wdata: wd};
        if (b == 0) q0.push_back(x);
        else q1.push_back(x);
    endtask

    task automatic queueRandom(input int b);
        int          r;
        logic [1:0]  tr;
        logic [31:0] a;
        logic [2:0]  sz;
        r  = $urandom_range(0, 9);
        tr = (r < 1) ? 2'b00 : (r < 2) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
        a  = BASE | 32'($urandom_range(0, 19) * 4);
        if ($urandom_range(0, 19) == 0) a[1:0] = 2'($urandom_range(1, 3));
        sz = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
        queueXfer(b, $urandom_range(0, 9) != 0, tr, 1'($urandom_range(0, 1)), a, sz, $urandom());
    endtask

    // One call per falling edge: check the data phase in flight, then present the next address phase.
    task automatic applyStimulus();
        xfer_t       x;
        logic        err;
        logic        cnt_wr;
        logic [31:0] cnt_val;
        int          idx;
        for (int b = 0; b < 2; b++) begin
            cnt_wr  = 1'b0;
            cnt_val = '0;
            if (!rst_n) begin
                cur_v[b] = 1'b0;
                nxt_v[b] = 1'b0;
                driveIdle(b);
                for (int r = 0; r < NUM_REGS; r++) mreg[b][r] = '0;
                mcnt[b] = '0;
            end else begin
                if (nxt_v[b]) begin
                    cur[b]   = nxt[b];
                    cur_v[b] = 1'b1;
                    nxt_v[b] = 1'b0;
                    waits[b] = 0;
                end
                checkOutput("irq", irq[b], mreg[b][2]);
                if (cur_v[b]) begin
                    x         = cur[b];
                    err       = isErr(x);
                    idx       = int'(x.addr[11:2]);
                    hwdata[b] = x.wr ? x.wdata : $urandom();
                    if (hready_out[b]) begin
                        checkOutput("waits", 32'(waits[b]), err ? 32'd1 : 32'(wsOf(b)));
                        checkOutput("hresp", {30'd0, hresp[b]}, err ? 32'd1 : 32'd0);
                        if (!err && !x.wr) checkOutput("hrdata", hrdata[b], modelRead(b, idx));
                        else checkOutput("hrdata_zero", hrdata[b], 32'd0);
                        if (!err && x.wr) begin
                            case (idx)
                                0: ;
                                2: mreg[b][2] = mreg[b][2] & ~x.wdata;
                                3: mreg[b][2] = mreg[b][2] | x.wdata;
                                4: begin cnt_wr = 1'b1; cnt_val = x.wdata; end
                                default: mreg[b][idx] = x.wdata;
                            endcase
                        end
                        cur_v[b] = 1'b0;
                    end else begin
                        checkOutput("hresp_wait", {30'd0, hresp[b]}, err ? 32'd1 : 32'd0);
                        checkOutput("hrdata_wait", hrdata[b], 32'd0);
                        waits[b]++;
                        if (waits[b] > 8) begin
                            checkOutput("wait_bound", 32'(waits[b]), 32'(wsOf(b)));
                            cur_v[b] = 1'b0;
                        end
                    end
                end else begin
                    hwdata[b] = $urandom();
                    checkOutput("hready_idle", {31'd0, hready_out[b]}, 32'd1);
                    checkOutput("hrdata_idle", hrdata[b], 32'd0);
                end
                if (hready_out[b]) begin
                    if ((b == 0) ? (q0.size() > 0) : (q1.size() > 0)) begin
                        if (b == 0) x = q0.pop_front();
                        else x = q1.pop_front();
                        hsel[b]   = x.sel;
                        htrans[b] = x.trans;
                        hwrite[b] = x.wr;
                        haddr[b]  = x.addr;
                        hsize[b]  = x.size;
                        if (isXfer(x)) begin
                            nxt[b]   = x;
                            nxt_v[b] = 1'b1;
                        end
                    end else begin
                        driveIdle(b);
                    end
                end
                mcnt[b] = cnt_wr ? cnt_val : mcnt[b] + 32'd1;
            end
        end
    endtask

    task automatic runUntilDone(input int budget);
        int   n;
        logic idle;
        n    = 0;
        idle = 1'b0;
        while (!idle && n < budget) begin
            @(negedge hclk);
            applyStimulus();
            n++;
            idle = (q0.size() == 0) && (q1.size() == 0) && !cur_v[0] && !cur_v[1]
                && !nxt_v[0] && !nxt_v[1];
        end
        checkOutput("drain", {31'd0, idle}, 32'd1);
    endtask

    initial begin
        logic reached;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        for (int b = 0; b < 2; b++) begin
            driveIdle(b);
            hwdata[b] = '0;
            cur_v[b]  = 1'b0;
            nxt_v[b]  = 1'b0;
            waits[b]  = 0;
        end
        repeat (3) begin
            @(negedge hclk);
            applyStimulus();
        end
        @(negedge hclk);
        rst_n = 1'b1;
        applyStimulus();

        for (int b = 0; b < 2; b++) begin
            queueXfer(b, 1, 2'b10, 0, BASE + 32'h00, 3'b010, 0);
            queueXfer(b, 1, 2'b10, 0, BASE + 32'h04, 3'b010, 0);
            queueXfer(b, 1, 2'b10, 1, BASE + 32'h04, 3'b010, 32'hA5A5_5A5A);
            queueXfer(b, 1, 2'b10, 0, BASE + 32'h04, 3'b010, 0);
            queueXfer(b, 1, 2'b10, 0, BASE + 32'h40, 3'b010, 0);
            queueXfer(b, 1, 2'b10, 1, BASE + 32'h06, 3'b010, 32'h1111_2222);
            queueXfer(b, 1, 2'b10, 1, BASE + 32'h04, 3'b000, 32'h3333_4444);
            queueXfer(b, 1, 2'b10, 0, BASE + 32'h04, 3'b010, 0);
            queueXfer(b, 1, 2'b10, 1, BASE + 32'h0C, 3'b010, 32'h0000_0011);
            queueXfer(b, 1, 2'b10, 1, BASE + 32'h08, 3'b010, 32'h0000_0001);
            queueXfer(b, 1, 2'b10, 0, BASE + 32'h0C, 3'b010, 0);
            queueXfer(b, 1, 2'b10, 0, BASE + 32'h08, 3'b010, 0);
            queueXfer(b, 1, 2'b10, 1, BASE + 32'h10, 3'b010, 32'hFFFF_FFFE);
            queueXfer(b, 0, 2'b00, 0, BASE, 3'b010, 0);
            queueXfer(b, 0, 2'b00, 0, BASE, 3'b010, 0);
            queueXfer(b, 1, 2'b10, 0, BASE + 32'h10, 3'b010, 0);
            queueXfer(b, 1, 2'b10, 1, BASE + 32'h10, 3'b010, 32'h1234_0000);
            queueXfer(b, 1, 2'b10, 0, BASE + 32'h10, 3'b010, 0);
            queueXfer(b, 1, 2'b10, 1, BASE + 32'h14, 3'b010, 32'hCAFE_0014);
            queueXfer(b, 1, 2'b10, 1, BASE + 32'h18, 3'b010, 32'hCAFE_0018);
            queueXfer(b, 1, 2'b10, 0, BASE + 32'h14, 3'b010, 0);
            queueXfer(b, 1, 2'b11, 0, BASE + 32'h18, 3'b010, 0);
            queueXfer(b, 1, 2'b01, 1, BASE + 32'h14, 3'b010, 32'hBAD0_0001);
            queueXfer(b, 1, 2'b00, 1, BASE + 32'h14, 3'b010, 32'hBAD0_0002);
            queueXfer(b, 0, 2'b10, 1, BASE + 32'h18, 3'b010, 32'hBAD0_0003);
            queueXfer(b, 1, 2'b10, 0, BASE + 32'h14, 3'b010, 0);
            queueXfer(b, 1, 2'b11, 0, BASE + 32'h18, 3'b010, 0);
        end
        runUntilDone(400);

        $display("[TB] reset during a wait-state data phase");
        for (int b = 0; b < 2; b++) queueXfer(b, 1, 2'b10, 1, BASE + 32'h04, 3'b010, 32'hDEAD_BEEF);
        reached = 1'b0;
        for (int n = 0; n < 20 && !reached; n++) begin
            @(negedge hclk);
            applyStimulus();
            reached = cur_v[1] && (waits[1] == 1);
        end
        checkOutput("reach_wait", {31'd0, reached}, 32'd1);
        @(negedge hclk);
        rst_n = 1'b0;
        applyStimulus();
        @(negedge hclk);
        for (int b = 0; b < 2; b++) begin
            checkOutput("rst_hready", {31'd0, hready_out[b]}, 32'd1);
            checkOutput("rst_hresp", {30'd0, hresp[b]}, 32'd0);
            checkOutput("rst_irq", irq[b], 32'd0);
            checkOutput("rst_hrdata", hrdata[b], 32'd0);
        end
        rst_n = 1'b1;
        applyStimulus();
        for (int b = 0; b < 2; b++) begin
            queueXfer(b, 1, 2'b10, 0, BASE + 32'h04, 3'b010, 0);
            queueXfer(b, 1, 2'b10, 0, BASE + 32'h00, 3'b010, 0);
            queueXfer(b, 1, 2'b10, 0, BASE + 32'h08, 3'b010, 0);
        end
        runUntilDone(100);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 200; i++) begin
            queueRandom(0);
            queueRandom(1);
        end
        runUntilDone(5000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
